// File: rtl/cbus_ram_responder_if.sv
// Cache-bus channel between a cache (master) and a memory responder (slave).
// creq carries the burst request and write data; cresp carries per-beat handshake and read data.
interface cbus_ram_responder_if;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;      // beats - 1
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);

endinterface

// File: rtl/cbus_ram_responder.sv
// Cache-bus responder backed by an on-chip word RAM.
// Serves wrapping (critical-word-first) read/write bursts with configurable first-beat latency.
module cbus_ram_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned FIRST_LAT  = 2,
  parameter int unsigned BEAT_GAP   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  cbus_ram_responder_if.slave  cbus
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StBeat, StGap} state_e;

  state_e                  state_q, state_d;
  logic                    is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [3:0]              len_q, len_d;
  logic [3:0]              beat_q, beat_d;
  logic [3:0]              lat_q, lat_d;
  logic [7:0]              gap_q, gap_d;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [Words];

  logic                    ready, last, wr_en;
  logic [ADDR_WIDTH-1:0]   rd_idx, wr_idx;
  logic                    unused_req_bits;

  assign unused_req_bits = ^{cbus.creq.size, cbus.creq.addr[31:ADDR_WIDTH+2],
                             cbus.creq.addr[1:0]};

  // Wrap block is beats rounded up to a power of two; the offset wraps inside that block.
  function automatic logic [ADDR_WIDTH-1:0] beat_idx(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [3:0]            beat,
                                                     input logic [3:0]            len);
    logic [3:0]            smear;
    logic [ADDR_WIDTH-1:0] mask;
    smear = len | (len >> 1) | (len >> 2) | (len >> 3);
    mask  = {{(ADDR_WIDTH-4){1'b0}}, smear};
    return (base & ~mask) | ((base + {{(ADDR_WIDTH-4){1'b0}}, beat}) & mask);
  endfunction

  assign ready  = (state_q == StBeat) && cbus.creq.valid;
  assign last   = ready && (beat_q == len_q);
  assign wr_en  = ready && is_write_q;
  assign rd_idx = beat_idx(base_d, beat_d, len_d);
  assign wr_idx = beat_idx(base_q, beat_q, len_q);

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    gap_d      = gap_q;
    case (state_q)
      StIdle: begin
        if (cbus.creq.valid) begin
          is_write_d = cbus.creq.is_write;
          base_d     = cbus.creq.addr[ADDR_WIDTH+1:2];
          len_d      = cbus.creq.len;
          beat_d     = 4'd0;
          lat_d      = 4'(FIRST_LAT - 1);
          state_d    = (FIRST_LAT <= 1) ? StBeat : StWait;
        end
      end
      StWait: begin
        if (!cbus.creq.valid) begin
          state_d = StIdle;
        end else if (lat_q <= 4'd1) begin
          state_d = StBeat;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StBeat: begin
        if (!cbus.creq.valid || last) begin
          state_d = StIdle;
        end else begin
          beat_d = beat_q + 4'd1;
          if (BEAT_GAP > 0) begin
            state_d = StGap;
            gap_d   = 8'(BEAT_GAP - 1);
          end
        end
      end
      StGap: begin
        if (!cbus.creq.valid) begin
          state_d = StIdle;
        end else if (gap_q == 8'd0) begin
          state_d = StBeat;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      base_q     <= '0;
      len_q      <= 4'd0;
      beat_q     <= 4'd0;
      lat_q      <= 4'd0;
      gap_q      <= 8'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      gap_q      <= gap_d;
      // Prefetch the word for the beat about to be served so it is registered on that cycle.
      rdata_q    <= mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (cbus.creq.strobe[b]) mem_q[wr_idx][8*b +: 8] <= cbus.creq.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    cbus.cresp.ready = ready;
    cbus.cresp.last  = last;
    cbus.cresp.data  = (state_q == StBeat && !is_write_q) ? rdata_q : 32'd0;
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for cbus_ram_responder: bursts, wrap order, byte strobes, gaps and reset.
module tb_cbus_ram_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cbus_ram_responder_if bus ();
  cbus_ram_responder_if bus_g ();

  cbus_ram_responder #(.ADDR_WIDTH(14), .FIRST_LAT(2), .BEAT_GAP(0)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .cbus   (bus.slave)
  );

  cbus_ram_responder #(.ADDR_WIDTH(14), .FIRST_LAT(2), .BEAT_GAP(1)) u_gap (
    .clk    (clk),
    .resetn (resetn),
    .cbus   (bus_g.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [15:0] lastv;
  int          first_lat;
  bit          tmo;

  // Drives one burst on the main DUT; call at posedge+1, returns at posedge+1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] size, input logic [3:0] strb);
    int n, cyc;
    n = 0; cyc = 0; first_lat = -1; lastv = '0;
    bus.creq.valid = 1'b1; bus.creq.is_write = wr; bus.creq.size = size;
    bus.creq.addr = addr; bus.creq.len = len; bus.creq.strobe = strb;
    bus.creq.data = wbuf[0];
    while (n <= int'(len) && cyc < 100) begin
      @(negedge clk);
      if (bus.cresp.ready) begin
        rbuf[n] = bus.cresp.data;
        lastv[n] = bus.cresp.last;
        if (first_lat < 0) first_lat = cyc;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (n <= int'(len)) bus.creq.data = wbuf[n];
    end
    bus.creq.valid = 1'b0;
    tmo = (n <= int'(len));
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.creq = '0;
    bus_g.creq = '0;
    @(posedge clk); #1;
    bus.creq.valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cresp.ready !== 1'b0 || bus.cresp.last !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: got ready=%b last=%b expected 0 0",
                         bus.cresp.ready, bus.cresp.last);
    end
    checks++;
    if (bus.cresp.data !== 32'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", bus.cresp.data);
    end
    checks++;
    if (bus_g.cresp.ready !== 1'b0) begin
      errors++; $display("FAIL reset_gap_ready: got %b expected 0", bus_g.cresp.ready);
    end
    bus.creq.valid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_burst();
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hA0 + i;
    xfer(1'b1, 32'h100, 4'd15, 2'd2, 4'hF);
    checks++;
    if (tmo) begin errors++; $display("FAIL preload_timeout: got timeout expected 16 beats"); end
    xfer(1'b0, 32'h100, 4'd15, 2'd2, 4'hF);
    checks++;
    if (first_lat !== 2) begin
      errors++; $display("FAIL read_latency: got %0d expected 2", first_lat);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rbuf[i] !== 32'hA0 + i) begin
        errors++; $display("FAIL read_data[%0d]: got %h expected %h", i, rbuf[i], 32'hA0 + i);
      end
    end
    checks++;
    if (lastv !== 16'h8000) begin
      errors++; $display("FAIL read_last: got %h expected 8000", lastv);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    xfer(1'b0, 32'h134, 4'd15, 2'd2, 4'hF);
    checks++;
    if (tmo) begin errors++; $display("FAIL wrap_timeout: got timeout expected 16 beats"); end
    for (int i = 0; i < 16; i++) begin
      exp = 32'hA0 + ((13 + i) % 16);
      checks++;
      if (rbuf[i] !== exp) begin
        errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rbuf[i], exp);
      end
    end
    checks++;
    if (lastv !== 16'h8000 || rbuf[15] !== 32'hAC) begin
      errors++; $display("FAIL wrap_last: got last=%h data=%h expected 8000 000000ac",
                         lastv, rbuf[15]);
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000 + i;
    xfer(1'b1, 32'h200, 4'd15, 2'd2, 4'hF);
    xfer(1'b0, 32'h200, 4'd15, 2'd2, 4'hF);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rbuf[i] !== 32'h1000 + i) begin
        errors++; $display("FAIL wr_rd_data[%0d]: got %h expected %h", i, rbuf[i], 32'h1000 + i);
      end
    end
  endtask

  task automatic test_single_strobe();
    wbuf[0] = 32'h11223344;
    xfer(1'b1, 32'h300, 4'd0, 2'd2, 4'hF);
    wbuf[0] = 32'h00EE0000;
    xfer(1'b1, 32'h302, 4'd0, 2'd0, 4'b0100);
    xfer(1'b0, 32'h300, 4'd0, 2'd2, 4'hF);
    checks++;
    if (rbuf[0] !== 32'h11EE3344) begin
      errors++; $display("FAIL single_strobe: got %h expected 11ee3344", rbuf[0]);
    end
    checks++;
    if (lastv[0] !== 1'b1 || first_lat !== 2) begin
      errors++; $display("FAIL single_last: got last=%b lat=%0d expected 1 2", lastv[0], first_lat);
    end
  endtask

  task automatic test_back_to_back();
    xfer(1'b0, 32'h100, 4'd3, 2'd2, 4'hF);
    xfer(1'b0, 32'h200, 4'd3, 2'd2, 4'hF);
    checks++;
    if (first_lat !== 2) begin
      errors++; $display("FAIL b2b_latency: got %0d expected 2", first_lat);
    end
    checks++;
    if (rbuf[0] !== 32'h1000 || rbuf[3] !== 32'h1003) begin
      errors++; $display("FAIL b2b_data: got %h %h expected 00001000 00001003", rbuf[0], rbuf[3]);
    end
  endtask

  task automatic test_valid_drop();
    bus.creq.valid = 1'b1; bus.creq.is_write = 1'b0; bus.creq.addr = 32'h100;
    bus.creq.len = 4'd15; bus.creq.size = 2'd2;
    @(posedge clk); #1;
    bus.creq.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cresp.ready !== 1'b0) begin
      errors++; $display("FAIL drop_ready: got %b expected 0", bus.cresp.ready);
    end
    @(posedge clk); #1;
    xfer(1'b0, 32'h104, 4'd0, 2'd2, 4'hF);
    checks++;
    if (first_lat !== 2 || rbuf[0] !== 32'hA1) begin
      errors++; $display("FAIL drop_recover: got lat=%0d data=%h expected 2 000000a1",
                         first_lat, rbuf[0]);
    end
  endtask

  task automatic test_gap();
    logic [8:0] rpat, lpat;
    rpat = '0; lpat = '0;
    bus_g.creq.valid = 1'b1; bus_g.creq.is_write = 1'b0; bus_g.creq.addr = 32'h0;
    bus_g.creq.len = 4'd3; bus_g.creq.size = 2'd2; bus_g.creq.strobe = 4'hF;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rpat = {rpat[7:0], bus_g.cresp.ready};
      lpat = {lpat[7:0], bus_g.cresp.last};
      @(posedge clk); #1;
    end
    bus_g.creq.valid = 1'b0;
    checks++;
    if (rpat !== 9'b001010101) begin
      errors++; $display("FAIL gap_ready: got %b expected 001010101", rpat);
    end
    checks++;
    if (lpat !== 9'b000000001) begin
      errors++; $display("FAIL gap_last: got %b expected 000000001", lpat);
    end
    @(negedge clk);
    checks++;
    if (bus_g.cresp.ready !== 1'b0) begin
      errors++; $display("FAIL gap_idle: got %b expected 0", bus_g.cresp.ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    int n, cyc;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hB0 + i;
    xfer(1'b1, 32'h400, 4'd15, 2'd2, 4'hF);
    for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0 + i;
    bus.creq.valid = 1'b1; bus.creq.is_write = 1'b1; bus.creq.addr = 32'h400;
    bus.creq.len = 4'd15; bus.creq.size = 2'd2; bus.creq.strobe = 4'hF;
    bus.creq.data = wbuf[0];
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(negedge clk);
      if (bus.cresp.ready) n++;
      @(posedge clk); #1;
      cyc++;
      bus.creq.data = wbuf[n];
    end
    checks++;
    if (n !== 5 || bus.cresp.ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup: got beats=%0d ready=%b expected 5 1",
                         n, bus.cresp.ready);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.cresp.ready !== 1'b0 || bus.cresp.last !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop: got ready=%b last=%b expected 0 0",
                         bus.cresp.ready, bus.cresp.last);
    end
    @(posedge clk); #1;
    bus.creq.valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h400, 4'd15, 2'd2, 4'hF);
    checks++;
    if (tmo || first_lat !== 2) begin
      errors++; $display("FAIL rst_mid_recover: got tmo=%b lat=%0d expected 0 2", tmo, first_lat);
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 5) ? 32'hC0 + i : 32'hB0 + i;
      checks++;
      if (rbuf[i] !== exp) begin
        errors++; $display("FAIL rst_mid_data[%0d]: got %h expected %h", i, rbuf[i], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_wrap();
    test_write_read();
    test_single_strobe();
    test_back_to_back();
    test_valid_drop();
    test_gap();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
